// File: rtl/pic_8259a_pkg.sv
// pic_8259a_pkg: init FSM states, OCW2 command codes and the priority search helper.
package pic_8259a_pkg;
   typedef enum logic [2:0] {S_IDLE, S_ICW2, S_ICW3, S_ICW4, S_READY} state_t;
   localparam logic [2:0] NSEOI = 3'b001;
   localparam logic [2:0] SEOI  = 3'b011;
   // Index of the lowest set bit (highest priority); 8 when the vector is empty.
   function automatic logic [3:0] lowest_set(input logic [7:0] v);
      lowest_set = 4'd8;
      for (int i = 7; i >= 0; i--) if (v[i]) lowest_set = 4'(i);
   endfunction
endpackage

// File: rtl/pic_8259a_priority.sv
// pic_8259a_priority: fully nested resolver, request wins only if strictly above every in-service level.
module pic_8259a_priority
   import pic_8259a_pkg::*;
(
   input  logic [7:0] i_irr,
   input  logic [7:0] i_imr,
   input  logic [7:0] i_isr,
   output logic       o_int_req,
   output logic [2:0] o_level
);
   logic [3:0] w_req_idx, w_isr_idx;
   assign w_req_idx = lowest_set(i_irr & ~i_imr);
   assign w_isr_idx = lowest_set(i_isr);
   assign o_int_req = w_req_idx < w_isr_idx;
   assign o_level   = w_req_idx[2:0];
endmodule

// File: rtl/pic_8259a.sv
// pic_8259a: 8259A-compatible interrupt controller, fully nested priority, 8086 vectors.
// Define PIC_CASCADE_EN to enable ICW3 storage and master/slave CAS cascading.
module pic_8259a
   import pic_8259a_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       CS,
   input  logic       WR,
   input  logic       RD,
   input  logic       A0,
   inout  wire  [7:0] D,
   inout  wire  [3:0] CAS,
   input  logic       SPEN,
   input  logic [7:0] IR,
   input  logic       INTA,
   output logic       INT
);
   state_t     r_state;
   logic       r_cs, r_wr, r_wr_d, r_rd, r_a0, r_inta, r_inta_d, r_spen;
   logic [2:0] r_cas, r_lvl;
   logic [7:0] r_wdata, r_ir, r_ir_d, r_imr, r_irr, r_isr;
   logic       r_ltim, r_sngl, r_ic4, r_aeoi, r_upm, r_ris, r_int;
   logic [4:0] r_base;
   logic [1:0] r_cnt;
   logic       w_int_req, w_commit, w_icw1, w_ocw2, w_fall, w_rise, w_ack;
   logic       w_vec, w_vec_en, w_cas_en, w_rd_en, w_unused;
   logic [2:0] w_level;
   logic [7:0] w_ack_mask, w_eoi_mask;

   pic_8259a_priority u_prio (
      .i_irr    (r_irr),
      .i_imr    (r_imr),
      .i_isr    (r_isr),
      .o_int_req(w_int_req),
      .o_level  (w_level)
   );

   always_ff @(posedge clk) begin
      if (!WR) r_wdata <= D;
      if (!rst_n) begin
         {r_cs, r_wr, r_wr_d, r_rd, r_inta, r_inta_d} <= '1;
         {r_ir, r_ir_d} <= '0;
      end else begin
         {r_cs, r_wr, r_wr_d, r_rd, r_a0} <= {CS, WR, r_wr, RD, A0};
         {r_inta, r_inta_d, r_spen, r_cas} <= {INTA, r_inta, SPEN, CAS[2:0]};
         {r_ir, r_ir_d} <= {IR, r_ir};
      end
   end

   assign w_commit   = r_wr && !r_wr_d && !r_cs;
   assign w_icw1     = w_commit && !r_a0 && r_wdata[4];
   assign w_ocw2     = w_commit && !r_a0 && r_wdata[4:3] == 2'b00;
   assign w_fall     = r_inta_d && !r_inta;
   assign w_rise     = !r_inta_d && r_inta;
   assign w_ack      = w_fall && r_cnt == 2'd0;
   assign w_ack_mask = w_ack && w_int_req ? 8'd1 << w_level : 8'd0;
   // r_cnt: 0 idle, 1 after first INTA, 2 during/after second INTA (vector phase)
   assign w_eoi_mask = (w_ocw2 && r_wdata[7:5] == NSEOI ? 8'd1 << lowest_set(r_isr) : 8'd0)
                     | (w_ocw2 && r_wdata[7:5] == SEOI ? 8'd1 << r_wdata[2:0] : 8'd0)
                     | (w_rise && r_cnt == 2'd2 && r_aeoi ? 8'd1 << r_lvl : 8'd0);
   assign w_vec      = r_cnt == 2'd2 && !r_inta;
   assign w_rd_en    = !r_cs && !r_rd;

`ifdef PIC_CASCADE_EN
   logic [7:0] r_icw3;
   assign w_cas_en = r_spen && !r_sngl && r_icw3[r_lvl] && r_cnt != 2'd0;
   assign w_vec_en = w_vec && (r_spen ? !w_cas_en : r_sngl || r_cas == r_icw3[2:0]);
`else
   assign w_cas_en = 1'b0;
   assign w_vec_en = w_vec;
`endif

   assign D        = w_vec_en ? {r_base, r_lvl} : w_rd_en ? (r_a0 ? r_imr : r_ris ? r_isr : r_irr) : 8'bz;
   assign CAS      = w_cas_en ? {1'bz, r_lvl} : 4'bz;
   assign INT      = r_int;
   assign w_unused = ^{r_upm, r_spen, r_cas, CAS[3]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         {r_ltim, r_sngl, r_ic4, r_aeoi, r_upm, r_ris, r_int} <= '0;
         r_imr <= 8'hFF;
         {r_irr, r_isr, r_base, r_cnt, r_lvl} <= '0;
`ifdef PIC_CASCADE_EN
         r_icw3 <= '0;
`endif
      end else if (w_icw1) begin
         r_state <= S_ICW2;
         {r_ltim, r_sngl, r_ic4} <= {r_wdata[3], r_wdata[1:0]};
         {r_aeoi, r_ris, r_int, r_cnt} <= '0;
         {r_imr, r_irr, r_isr} <= '0;
      end else begin
         if (w_commit && r_a0)
            case (r_state)
               S_ICW2: begin
                  r_base  <= r_wdata[7:3];
                  r_state <= !r_sngl ? S_ICW3 : r_ic4 ? S_ICW4 : S_READY;
               end
               S_ICW3: begin
`ifdef PIC_CASCADE_EN
                  r_icw3  <= r_wdata;
`endif
                  r_state <= r_ic4 ? S_ICW4 : S_READY;
               end
               S_ICW4: begin
                  {r_aeoi, r_upm} <= r_wdata[1:0];
                  r_state <= S_READY;
               end
               S_READY: r_imr <= r_wdata;
               default: ;
            endcase
         if (w_commit && !r_a0 && r_wdata[4:3] == 2'b01 && r_wdata[1]) r_ris <= r_wdata[0];
         r_irr <= (r_ltim ? r_ir : r_irr | (r_ir & ~r_ir_d)) & ~w_ack_mask;
         r_isr <= (r_isr | w_ack_mask) & ~w_eoi_mask;
         if (w_fall) r_cnt <= r_cnt == 2'd0 ? 2'd1 : 2'd2;
         else if (w_rise && r_cnt == 2'd2) r_cnt <= 2'd0;
         if (w_ack) r_lvl <= w_int_req ? w_level : 3'd7;
         r_int <= r_state == S_READY && w_int_req && r_cnt == 2'd0 && !w_fall;
      end
   end
endmodule

// File: tb/tb_pic_8259a.sv
// tb_pic_8259a: directed checks of init, nesting, EOI, masking, AEOI, abort, reset and cascade.
module tb_pic_8259a;
   logic       clk = 0, rst_n = 0, CS = 1, WR = 1, RD = 1, A0 = 0, INTA = 1, den = 0;
   logic       s_cs = 1, s_int;
   logic [7:0] IR = 0, s_ir = 0, dd = 0, rv;
   logic [2:0] s_cas = 0;
   logic       INT;
   wire  [7:0] d_m;
   wire  [3:0] cas_m;
   int         n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;
   assign d_m = den ? dd : 8'bz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (d_m[g]);
      if (g < 4) begin : g_cas
         pullup (cas_m[g]);
      end
   end

   pic_8259a u_dut (
      .clk(clk), .rst_n(rst_n), .CS(CS), .WR(WR), .RD(RD), .A0(A0), .D(d_m),
      .CAS(cas_m), .SPEN(1'b1), .IR(IR), .INTA(INTA), .INT(INT)
   );

`ifdef PIC_CASCADE_EN
   wire [7:0] d_s;
   wire [3:0] cas_s;
   assign d_s   = den ? dd : 8'bz;
   assign cas_s = {1'bz, s_cas};
   pic_8259a u_slv (
      .clk(clk), .rst_n(rst_n), .CS(s_cs), .WR(WR), .RD(RD), .A0(A0), .D(d_s),
      .CAS(cas_s), .SPEN(1'b0), .IR(s_ir), .INTA(INTA), .INT(s_int)
   );
`else
   assign s_int = 1'b0;
`endif

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic wr(input logic slv, input logic a, input logic [7:0] v);
      @(negedge clk);
      CS = slv; s_cs = !slv; A0 = a; dd = v; den = 1; WR = 0;
      @(negedge clk);
      WR = 1;
      tick(3);
      CS = 1; s_cs = 1; den = 0;
      tick(1);
   endtask

   task automatic rd(input logic a, output logic [7:0] v);
      @(negedge clk);
      CS = 0; A0 = a; RD = 0;
      tick(2);
      v = d_m;
      RD = 1; CS = 1;
      tick(2);
   endtask

   task automatic inta_lo;
      @(negedge clk);
      INTA = 0;
      tick(2);
   endtask

   task automatic inta_hi;
      INTA = 1;
      tick(2);
   endtask

   task automatic pair(output logic [7:0] v);
      inta_lo; inta_hi; inta_lo;
      v = d_m;
      inta_hi;
   endtask

   initial begin
      tick(3);
      chk("rst_int", {7'd0, INT}, 8'h00);
      chk("rst_d_z", d_m, 8'hFF);
      chk("rst_cas_z", {4'h0, cas_m}, 8'h0F);
      rst_n = 1;
      tick(2);
      rd(1, rv); chk("rst_imr", rv, 8'hFF);
      rd(0, rv); chk("rst_irr", rv, 8'h00);
      wr(0, 0, 8'h13); wr(0, 1, 8'hA8); wr(0, 1, 8'h01); wr(0, 1, 8'h00);
      rd(1, rv); chk("init_imr", rv, 8'h00);
      chk("init_int", {7'd0, INT}, 8'h00);
      IR = 8'h01; tick(4);
      chk("ir0_int", {7'd0, INT}, 8'h01);
      inta_lo; inta_hi;
      chk("ack1_int", {7'd0, INT}, 8'h00);
      wr(0, 0, 8'h0B); rd(0, rv); chk("ack1_isr", rv, 8'h01);
      inta_lo; chk("vec_a8", d_m, 8'hA8); inta_hi;
      chk("vec_release", d_m, 8'hFF);
      wr(0, 0, 8'h20); rd(0, rv); chk("nseoi_isr", rv, 8'h00);
      IR = 8'h82; tick(4);
      chk("ir17_int", {7'd0, INT}, 8'h01);
      pair(rv); chk("vec_a9", rv, 8'hA9);
      tick(2); chk("nested_int", {7'd0, INT}, 8'h00);
      wr(0, 0, 8'h20);
      pair(rv); chk("vec_af", rv, 8'hAF);
      wr(0, 0, 8'h20);
      IR = 8'h00; tick(2);
      wr(0, 1, 8'h02);
      IR = 8'h02; tick(4);
      chk("masked_int", {7'd0, INT}, 8'h00);
      wr(0, 0, 8'h0A); rd(0, rv); chk("masked_irr", rv, 8'h02);
      wr(0, 1, 8'h00); tick(2);
      chk("unmask_int", {7'd0, INT}, 8'h01);
      pair(rv); chk("unmask_vec", rv, 8'hA9);
      wr(0, 0, 8'h20);
      IR = 8'h00;
      wr(0, 0, 8'h13); wr(0, 1, 8'hA8); wr(0, 1, 8'h03); wr(0, 1, 8'h00);
      IR = 8'h08; tick(4);
      chk("aeoi_int", {7'd0, INT}, 8'h01);
      pair(rv); chk("aeoi_vec", rv, 8'hAB);
      wr(0, 0, 8'h0B); rd(0, rv); chk("aeoi_isr", rv, 8'h00);
      chk("aeoi_int_low", {7'd0, INT}, 8'h00);
      IR = 8'h18; tick(4);
      chk("abort_int_hi", {7'd0, INT}, 8'h01);
      inta_lo; inta_hi;
      wr(0, 0, 8'h13); wr(0, 1, 8'hA8); wr(0, 1, 8'h01);
      inta_lo;
      chk("abort_d_z", d_m, 8'hFF);
      chk("abort_int", {7'd0, INT}, 8'h00);
      inta_hi;
      rst_n = 0; tick(1); rst_n = 1; tick(1);
      rd(1, rv); chk("rerst_imr", rv, 8'hFF);
      chk("rerst_int", {7'd0, INT}, 8'h00);
`ifdef PIC_CASCADE_EN
      IR = 8'h00;
      wr(0, 0, 8'h11); wr(0, 1, 8'hA8); wr(0, 1, 8'h04); wr(0, 1, 8'h01); wr(0, 1, 8'h00);
      wr(1, 0, 8'h11); wr(1, 1, 8'hB0); wr(1, 1, 8'h02); wr(1, 1, 8'h01); wr(1, 1, 8'h00);
      IR = 8'h04; s_ir = 8'h01; s_cas = 3'd2; tick(4);
      chk("cas_ints", {6'd0, s_int, INT}, 8'h03);
      inta_lo;
      chk("cas_drive1", {4'h0, cas_m}, 8'h0A);
      inta_hi; inta_lo;
      chk("cas_drive2", {4'h0, cas_m}, 8'h0A);
      chk("cas_master_d_z", d_m, 8'hFF);
      chk("cas_slave_vec", d_s, 8'hB0);
      inta_hi;
      chk("cas_release", {4'h0, cas_m}, 8'h0F);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
